// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one burst-read / single-write memory port between the
// instruction cache (read-only) and the data cache (read/write). The data side
// wins ties, but after MAX_D_STREAK consecutive data grants taken while the
// instruction side was waiting, the instruction side is served next.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LEN    = 4,
  parameter int MAX_D_STREAK = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  // instruction side
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd,
  output logic                  i_waitrequest,
  output logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  i_rd_valid,
  // data side
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_rd,
  input  logic                  d_wr,
  input  logic [DATA_WIDTH-1:0] d_wr_data,
  output logic                  d_waitrequest,
  output logic [DATA_WIDTH-1:0] d_rd_data,
  output logic                  d_rd_valid,
  // memory side
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_waitrequest,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic                  stray_beat
);

  localparam int BEAT_W   = $clog2(BURST_LEN + 1);
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RD_WAIT} state_e;

  state_e                state_q, state_d;
  logic                  d_owner_q, d_owner_d;   // 1: data side owns the port
  logic                  is_wr_q, is_wr_d;       // granted command is a write
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic [DATA_WIDTH-1:0] i_data_q, d_data_q;     // last beat delivered per side

  logic d_req;
  logic beat_in;

  assign d_req   = d_rd | d_wr;
  assign beat_in = (state_q == RD_WAIT) && mem_rd_valid;

  // Handshake and read-return paths are combinational so beats reach the
  // owner with zero latency; the non-owner keeps showing its last beat.
  assign i_waitrequest = !((state_q == GNT_I) && !mem_waitrequest);
  assign d_waitrequest = !((state_q == GNT_D) && !mem_waitrequest);
  assign i_rd_valid    = beat_in && !d_owner_q;
  assign d_rd_valid    = beat_in &&  d_owner_q;
  assign i_rd_data     = i_rd_valid ? mem_rd_data : i_data_q;
  assign d_rd_data     = d_rd_valid ? mem_rd_data : d_data_q;
  assign stray_beat    = mem_rd_valid && (state_q != RD_WAIT);

  // Memory command mux: present the owner's request while granted.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    mem_addr    = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wr_data = '0;
    case (state_q)
      GNT_I: begin
        mem_addr = i_addr;
        mem_rd   = 1'b1;
      end
      GNT_D: begin
        mem_addr    = d_addr;
        mem_rd      = !is_wr_q;
        mem_wr      = is_wr_q;
        mem_wr_data = d_wr_data;
      end
      default: ;
    endcase
  end

  // Next-state logic: arbitration, acceptance and beat counting.
  always_comb begin
    state_d   = state_q;
    d_owner_d = d_owner_q;
    is_wr_d   = is_wr_q;
    beat_d    = beat_q;
    streak_d  = streak_q;
    case (state_q)
      IDLE: begin
        if (!i_rd) streak_d = '0;
        if (d_req && (!i_rd || (streak_q != STREAK_MAX))) begin
          state_d   = GNT_D;
          d_owner_d = 1'b1;
          is_wr_d   = d_wr;                // write wins over a simultaneous read
          // Only reachable below the limit, so the streak saturates by construction.
          if (i_rd) streak_d = streak_q + STREAK_W'(1);
        end else if (i_rd) begin
          state_d   = GNT_I;
          d_owner_d = 1'b0;
          is_wr_d   = 1'b0;
          streak_d  = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (!mem_waitrequest) begin
          if (is_wr_q) begin
            state_d = IDLE;
          end else begin
            state_d = RD_WAIT;
            beat_d  = '0;
          end
        end
      end
      RD_WAIT: begin
        if (mem_rd_valid) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset abandons any transaction.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      d_owner_q <= 1'b0;
      is_wr_q   <= 1'b0;
      beat_q    <= '0;
      streak_q  <= '0;
      i_data_q  <= '0;
      d_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      d_owner_q <= d_owner_d;
      is_wr_q   <= is_wr_d;
      beat_q    <= beat_d;
      streak_q  <= streak_d;
      i_data_q  <= i_rd_data;
      d_data_q  <= d_rd_data;
    end
  end

`ifndef SYNTHESIS
  // A granted requester must hold its request until the command is accepted.
  a_i_hold: assert property (@(posedge clock) disable iff (reset)
    (state_q == GNT_I) |-> i_rd);
  a_d_hold: assert property (@(posedge clock) disable iff (reset)
    (state_q == GNT_D) |-> (is_wr_q ? d_wr : d_rd));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected commands and
// beats into queues; a monitor pops and compares whenever the DUT presents
// a memory command or a read beat. A small memory model answers commands.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic          i_rd, d_rd, d_wr;
  logic [DW-1:0] d_wr_data, i_rd_data, d_rd_data, mem_wr_data, mem_rd_data;
  logic          i_waitrequest, i_rd_valid, d_waitrequest, d_rd_valid;
  logic          mem_rd, mem_wr, mem_waitrequest, mem_rd_valid, stray_beat;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .MAX_D_STREAK(3)) dut (
    .clock(clock), .reset(reset),
    .i_addr(i_addr), .i_rd(i_rd), .i_waitrequest(i_waitrequest),
    .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid),
    .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wr_data(d_wr_data),
    .d_waitrequest(d_waitrequest), .d_rd_data(d_rd_data), .d_rd_valid(d_rd_valid),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data),
    .mem_waitrequest(mem_waitrequest), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .stray_beat(stray_beat)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic        wr;
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] data;
    int          cycles;
  } cmd_t;

  typedef struct {
    int          c;
    logic [31:0] d;
  } beat_t;

  cmd_t        cmd_q[$];
  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];
  beat_t       mem_beats[$];

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cfg = 0;
  int gap_cfg   = 0;
  int i_beats_seen = 0, d_beats_seen = 0, stray_seen = 0, last_d_beat_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s", msg);
  endtask

  // Memory model contents: beat k of a burst from address a.
  function automatic logic [31:0] beat_val(input logic [31:0] a, input int k);
    return 32'hA000_0000 + (a << 4) + 32'(k);
  endfunction

  // Memory model: stalls each command stall_cfg cycles, then returns BL beats
  // starting the cycle after accept, gap_cfg idle cycles between beats.
  initial begin
    beat_t b;
    int    stall_left;
    bit    in_cmd;
    stall_left = 0;
    in_cmd = 0;
    mem_waitrequest = 1'b0;
    mem_rd_valid    = 1'b0;
    mem_rd_data     = '0;
    forever begin
      @(negedge clock);
      mem_rd_valid = 1'b0;
      if (mem_beats.size() > 0 && mem_beats[0].c == cyc) begin
        b = mem_beats.pop_front();
        mem_rd_valid = 1'b1;
        mem_rd_data  = b.d;
      end
      if (mem_rd || mem_wr) begin
        if (!in_cmd) begin
          in_cmd = 1;
          stall_left = stall_cfg;
        end
        if (stall_left > 0) begin
          mem_waitrequest = 1'b1;
          stall_left--;
        end else begin
          mem_waitrequest = 1'b0;
          in_cmd = 0;
          if (mem_rd)
            for (int k = 0; k < BL; k++) begin
              b.c = cyc + 1 + k * (gap_cfg + 1);
              b.d = beat_val(mem_addr, k);
              mem_beats.push_back(b);
            end
        end
      end else begin
        mem_waitrequest = 1'b0;
        in_cmd = 0;
      end
    end
  end

  // Monitor: compares every presented command and beat against the queues.
  initial begin
    cmd_t e;
    int   cmd_run;
    cmd_run = 0;
    forever begin
      @(negedge clock); #2;
      if (reset) begin
        cmd_run = 0;
        continue;
      end
      if (i_rd_valid) begin
        i_beats_seen++;
        if (i_exp_q.size() == 0)
          fail_now($sformatf("i_beat: got unexpected beat 0x%0h, expected none", i_rd_data));
        else
          check("i_beat", i_rd_data, i_exp_q.pop_front());
      end
      if (d_rd_valid) begin
        d_beats_seen++;
        last_d_beat_cyc = cyc;
        if (d_exp_q.size() == 0)
          fail_now($sformatf("d_beat: got unexpected beat 0x%0h, expected none", d_rd_data));
        else
          check("d_beat", d_rd_data, d_exp_q.pop_front());
      end
      if (stray_beat) stray_seen++;
      if (mem_rd || mem_wr) begin
        cmd_run++;
        if (cmd_q.size() == 0) begin
          fail_now($sformatf("cmd: got unexpected rd=%0b wr=%0b addr=0x%0h, expected none",
                             mem_rd, mem_wr, mem_addr));
        end else begin
          e = cmd_q[0];
          check("cmd_wr", mem_wr, e.wr);
          check("cmd_rd", mem_rd, !e.wr);
          check("cmd_addr", mem_addr, e.addr);
          if (e.wr) check("cmd_wdata", mem_wr_data, e.data);
          if (mem_waitrequest) begin
            check("i_wait_stalled", i_waitrequest, 1'b1);
            check("d_wait_stalled", d_waitrequest, 1'b1);
          end else begin
            check("i_wait_accept", i_waitrequest, e.is_d);
            check("d_wait_accept", d_waitrequest, !e.is_d);
            check("cmd_cycles", cmd_run, e.cycles);
            e = cmd_q.pop_front();
            cmd_run = 0;
          end
        end
      end else begin
        cmd_run = 0;
        check("i_wait_idle", i_waitrequest, 1'b1);
        check("d_wait_idle", d_waitrequest, 1'b1);
      end
    end
  end

  function automatic cmd_t mk_cmd(input logic wr, input logic is_d, input logic [31:0] a,
                                  input logic [31:0] d, input int cycles);
    cmd_t c;
    c.wr = wr; c.is_d = is_d; c.addr = a; c.data = d; c.cycles = cycles;
    return c;
  endfunction

  // I-side read; entered just after a posedge, returns just after the accept edge.
  task automatic i_read(input logic [31:0] a, input bit keep, output int acc_cyc);
    bit done;
    done = 0;
    acc_cyc = -1;
    i_addr = a;
    i_rd   = 1'b1;
    for (int k = 0; k < BL; k++) i_exp_q.push_back(beat_val(a, k));
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clock); #3;
      if (!i_waitrequest) begin
        done = 1;
        acc_cyc = cyc;
      end
    end
    if (!done) fail_now($sformatf("i_accept_timeout: addr 0x%0h not accepted, expected accept", a));
    @(posedge clock); #1;
    if (!keep) i_rd = 1'b0;
  endtask

  // D-side command; nexp read beats are expected to be forwarded.
  task automatic d_cmd(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                       input bit keep, input int nexp, output int acc_cyc);
    bit done;
    done = 0;
    acc_cyc = -1;
    d_addr    = a;
    d_rd      = rd;
    d_wr      = wr;
    d_wr_data = wd;
    if (!wr) for (int k = 0; k < nexp; k++) d_exp_q.push_back(beat_val(a, k));
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clock); #3;
      if (!d_waitrequest) begin
        done = 1;
        acc_cyc = cyc;
      end
    end
    if (!done) fail_now($sformatf("d_accept_timeout: addr 0x%0h not accepted, expected accept", a));
    @(posedge clock); #1;
    if (!keep) begin
      d_rd = 1'b0;
      d_wr = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((i_exp_q.size() > 0 || d_exp_q.size() > 0 || cmd_q.size() > 0 || mem_beats.size() > 0)
           && t < 200) begin
      @(negedge clock); #3;
      t++;
    end
    check({tag, "_i_beats_left"}, i_exp_q.size(), 0);
    check({tag, "_d_beats_left"}, d_exp_q.size(), 0);
    check({tag, "_cmds_left"}, cmd_q.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd"}, mem_rd, 1'b0);
    check({tag, "_mem_wr"}, mem_wr, 1'b0);
    check({tag, "_i_wait"}, i_waitrequest, 1'b1);
    check({tag, "_d_wait"}, d_waitrequest, 1'b1);
    check({tag, "_i_valid"}, i_rd_valid, 1'b0);
    check({tag, "_d_valid"}, d_rd_valid, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wr_data, 32'h0);
    check({tag, "_i_data"}, i_rd_data, 32'h0);
    check({tag, "_d_data"}, d_rd_data, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, acc2, base;
    reset = 1'b1;
    i_addr = '0; i_rd = 1'b0;
    d_addr = '0; d_rd = 1'b0; d_wr = 1'b0; d_wr_data = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock); #3;
    check_reset_outputs("rst");
    check("rst_stray", stray_beat, 1'b0);
    @(posedge clock); #1;

    // 1: lone I read of 0x100, no stalls, four beats back to I only.
    cmd_q.push_back(mk_cmd(1'b0, 1'b0, 32'h100, 32'h0, 1));
    i_read(32'h100, 0, acc);
    drain("t1");

    // 2: D write stalled three cycles, command held stable four cycles.
    stall_cfg = 3;
    cmd_q.push_back(mk_cmd(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4));
    d_cmd(32'h200, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, 0, acc);
    stall_cfg = 0;
    drain("t2");

    // 3: both sides read continuously; expected grant order D,D,D,I,D,D,D,I.
    cmd_q.push_back(mk_cmd(1'b0, 1'b1, 32'h2000, 32'h0, 1));
    cmd_q.push_back(mk_cmd(1'b0, 1'b1, 32'h2010, 32'h0, 1));
    cmd_q.push_back(mk_cmd(1'b0, 1'b1, 32'h2020, 32'h0, 1));
    cmd_q.push_back(mk_cmd(1'b0, 1'b0, 32'h1000, 32'h0, 1));
    cmd_q.push_back(mk_cmd(1'b0, 1'b1, 32'h2030, 32'h0, 1));
    cmd_q.push_back(mk_cmd(1'b0, 1'b1, 32'h2040, 32'h0, 1));
    cmd_q.push_back(mk_cmd(1'b0, 1'b1, 32'h2050, 32'h0, 1));
    cmd_q.push_back(mk_cmd(1'b0, 1'b0, 32'h1010, 32'h0, 1));
    fork
      begin
        int a3;
        for (int k = 0; k < 6; k++) d_cmd(32'h2000 + 32'(16 * k), 1'b1, 1'b0, 32'h0, (k < 5), BL, a3);
      end
      begin
        int a4;
        for (int k = 0; k < 2; k++) i_read(32'h1000 + 32'(16 * k), (k < 1), a4);
      end
    join
    drain("t3");

    // 4: D read with 2-cycle beat gaps; the pending D request waits for the
    //    last beat plus one idle cycle.
    gap_cfg = 2;
    cmd_q.push_back(mk_cmd(1'b0, 1'b1, 32'h600, 32'h0, 1));
    cmd_q.push_back(mk_cmd(1'b0, 1'b1, 32'h610, 32'h0, 1));
    d_cmd(32'h600, 1'b1, 1'b0, 32'h0, 1, BL, acc);
    d_cmd(32'h610, 1'b1, 1'b0, 32'h0, 0, BL, acc2);
    check("t4_grant_after_last_beat", acc2, last_d_beat_cyc + 2);
    gap_cfg = 0;
    drain("t4");
    check("t4_i_data_hold", i_rd_data, beat_val(32'h1010, 3));

    // 5: reset after two of four beats; the remaining two are flagged as strays.
    gap_cfg = 1;
    base = d_beats_seen;
    cmd_q.push_back(mk_cmd(1'b0, 1'b1, 32'h500, 32'h0, 1));
    d_cmd(32'h500, 1'b1, 1'b0, 32'h0, 0, 2, acc);
    for (int t = 0; t < 100 && d_beats_seen < base + 2; t++) begin
      @(negedge clock); #3;
    end
    check("t5_beats_before_reset", d_beats_seen, base + 2);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock); #3;
    check("t5_stray_pulse", stray_beat, 1'b1);
    check_reset_outputs("t5");
    repeat (4) @(posedge clock);
    #1;
    check("t5_stray_count", stray_seen, 2);
    gap_cfg = 0;
    drain("t5");

    // 6: d_rd+d_wr with i_rd and streak 0: the write goes first, then the I read.
    cmd_q.push_back(mk_cmd(1'b1, 1'b1, 32'h300, 32'h1234_5678, 1));
    cmd_q.push_back(mk_cmd(1'b0, 1'b0, 32'h400, 32'h0, 1));
    fork
      begin
        int a5;
        d_cmd(32'h300, 1'b1, 1'b1, 32'h1234_5678, 0, 0, a5);
      end
      begin
        int a6;
        i_read(32'h400, 0, a6);
      end
    join
    drain("t6");

    check("stray_total", stray_seen, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
